// File: rtl/iob_iob2wishbone_pkg.sv
// +----------------------------------------------------------------------+
// | iob_iob2wishbone_pkg: shared state encoding and helpers for the bridge |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package iob_iob2wishbone_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUS     = 2'd1,
        ST_BACKOFF = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    // Counter width able to hold max_val; a zero limit still needs one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/iob_iob2wishbone_cnt.sv
// +----------------------------------------------------------------------+
// | iob_iob2wishbone_cnt: saturating counter with clear, enable, tc flag |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module iob_iob2wishbone_cnt
    import iob_iob2wishbone_pkg::*;
#(
    parameter int MAX = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int             W     = cnt_width(MAX);
    localparam logic [W-1:0]   MAX_V = W'(MAX);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != MAX_V)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == MAX_V);

endmodule

`default_nettype wire

// File: rtl/iob_iob2wishbone.sv
// +----------------------------------------------------------------------+
// | iob_iob2wishbone: IOb slave to classic Wishbone master bridge        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module iob_iob2wishbone
    import iob_iob2wishbone_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 255,
    parameter int RETRY_MAX = 3
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                valid_i,
    input  logic [ADDR_W-1:0]   address_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                ready_o,
    output logic                error_o,
    output logic [ADDR_W-1:0]   wb_addr_o,
    output logic [DATA_W-1:0]   wb_data_o,
    output logic [DATA_W/8-1:0] wb_select_o,
    output logic                wb_we_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    input  logic [DATA_W-1:0]   wb_data_i,
    input  logic                wb_ack_i,
    input  logic                wb_err_i,
    input  logic                wb_rty_i
);

    localparam int   STRB_W     = DATA_W / 8;
    localparam logic TIMEOUT_EN = (TIMEOUT != 0);

    state_t              state;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [STRB_W-1:0]   sel_r;
    logic                we_r;
    logic                cyc_r;
    logic                ready_r;
    logic                error_r;
    logic [DATA_W-1:0]   rdata_r;

    logic to_tc;
    logic rty_tc;
    logic to_hit;
    logic bus_retry;
    logic bus_fail;

    assign to_hit = TIMEOUT_EN & to_tc;

    // A non-exhausted retry outranks the timeout; ack outranks everything.
    assign bus_retry = ~wb_ack_i & ~wb_err_i & wb_rty_i & ~rty_tc;
    assign bus_fail  = ~wb_ack_i & (wb_err_i | (wb_rty_i ? rty_tc : to_hit));

    iob_iob2wishbone_cnt #(
        .MAX (TIMEOUT)
    ) u_timeout_cnt (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .clr   (state != ST_BUS),
        .en    (state == ST_BUS),
        .tc    (to_tc)
    );

    iob_iob2wishbone_cnt #(
        .MAX (RETRY_MAX)
    ) u_retry_cnt (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .clr   (state == ST_IDLE),
        .en    ((state == ST_BUS) & bus_retry),
        .tc    (rty_tc)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state   <= ST_IDLE;
            addr_r  <= '0;
            wdata_r <= '0;
            sel_r   <= '0;
            we_r    <= 1'b0;
            cyc_r   <= 1'b0;
            ready_r <= 1'b0;
            error_r <= 1'b0;
            rdata_r <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (valid_i) begin
                        addr_r  <= address_i;
                        wdata_r <= wdata_i;
                        we_r    <= |wstrb_i;
                        sel_r   <= (|wstrb_i) ? wstrb_i : '1;
                        cyc_r   <= 1'b1;
                        state   <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (wb_ack_i) begin
                        if (!we_r) begin
                            rdata_r <= wb_data_i;
                        end
                        error_r <= 1'b0;
                        ready_r <= 1'b1;
                        cyc_r   <= 1'b0;
                        state   <= ST_RESP;
                    end else if (bus_fail) begin
                        error_r <= 1'b1;
                        rdata_r <= '1;
                        ready_r <= 1'b1;
                        cyc_r   <= 1'b0;
                        state   <= ST_RESP;
                    end else if (bus_retry) begin
                        cyc_r <= 1'b0;
                        state <= ST_BACKOFF;
                    end
                end
                ST_BACKOFF: begin
                    cyc_r <= 1'b1;
                    state <= ST_BUS;
                end
                ST_RESP: begin
                    ready_r <= 1'b0;
                    error_r <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rdata_o     = rdata_r;
    assign ready_o     = ready_r;
    assign error_o     = error_r;
    assign wb_addr_o   = addr_r;
    assign wb_data_o   = wdata_r;
    assign wb_select_o = sel_r;
    assign wb_we_o     = we_r;
    assign wb_cyc_o    = cyc_r;
    assign wb_stb_o    = cyc_r;

endmodule

`default_nettype wire
